srl_iter: RTL



---
 rtl/srl_pkg.sv | 15 +
 rtl/srl_step.sv | 21 ++
 rtl/srl_iter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/srl_pkg.sv
// Shared types and constants for the iterative right-shift unit.
package srl_pkg;

  // Control FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } srl_state_t;

  // Fill-mode encoding for bits entering at the MSB side.
  localparam logic FillZero = 1'b0;
  localparam logic FillSign = 1'b1;

endpackage

// File: rtl/srl_step.sv
// One shift step: moves the word right by n (0..STEP) bits, filling the vacated MSBs with fill_bit.
module srl_step #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1,
  parameter int unsigned NW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] y,
  input  logic [NW-1:0]    n,
  input  logic             fill_bit,
  output logic [WIDTH-1:0] shifted
);

  logic [WIDTH+STEP-1:0] ext;

  // Pre-extend with STEP fill bits so a plain logical shift yields the right fill.
  always_comb begin
    ext     = {{STEP{fill_bit}}, y};
    shifted = WIDTH'(ext >> n);
  end

endmodule

// File: rtl/srl_iter.sv
// Iterative shift-right unit: accepts (a, shamt) over a valid/ready handshake, shifts right by up
// to STEP bits per clock, then presents y until the consumer takes it.
// Optional feature macro: SRL_ARITH_EN adds the arith port (sign-fill shift when arith=1).
module srl_iter
  import srl_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned STEP    = 1,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] shamt,
`ifdef SRL_ARITH_EN
  input  logic               arith,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   y,
  output logic               busy
);

  localparam int unsigned NW = $clog2(STEP + 1);

  srl_state_t         state_q, state_d;
  logic [WIDTH-1:0]   y_q;
  logic [SHAMT_W-1:0] rem_q;
  logic [SHAMT_W-1:0] rem_after;
  logic [SHAMT_W-1:0] shamt_sat;
  logic [NW-1:0]      step_n;
  logic [31:0]        step_n_wide;
  logic [WIDTH-1:0]   shifted;
  logic               fill_bit;
  logic               accept;

  assign accept = in_valid && (state_q == IDLE);

  // Per-cycle shift amount n = min(STEP, rem) and the remaining count after this step.
  always_comb begin
    step_n_wide = (32'(rem_q) > STEP) ? STEP : 32'(rem_q);
    step_n      = NW'(step_n_wide);
    rem_after   = rem_q - SHAMT_W'(step_n_wide);
  end

  // Out-of-range amounts (only encodable for non-power-of-two WIDTH) clamp to WIDTH-1.
  always_comb begin
    shamt_sat = shamt;
    if (32'(shamt) > (WIDTH - 1)) begin
      shamt_sat = SHAMT_W'(WIDTH - 1);
    end
  end

`ifdef SRL_ARITH_EN
  logic fill_mode_q;

  // Fill mode is latched with the operand; the MSB never changes during an arithmetic shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_mode_q <= FillZero;
    end else if (accept) begin
      fill_mode_q <= arith ? FillSign : FillZero;
    end
  end

  assign fill_bit = (fill_mode_q == FillSign) ? y_q[WIDTH-1] : 1'b0;
`else
  assign fill_bit = 1'b0;
`endif

  srl_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .y        (y_q),
    .n        (step_n),
    .fill_bit (fill_bit),
    .shifted  (shifted)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a handoff in DONE always returns to IDLE first, so no back-to-back accept.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = (shamt_sat == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (rem_after == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture on accept, shift while in SHIFT, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q   <= '0;
      rem_q <= '0;
    end else if (accept) begin
      y_q   <= a;
      rem_q <= shamt_sat;
    end else if (state_q == SHIFT) begin
      y_q   <= shifted;
      rem_q <= rem_after;
    end
  end

  // Handshake and status outputs decoded from the state.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  assign y = y_q;

endmodule
